c_cache_stage: RTL and testbench

//  Cache (C) stage of the data-memory pipe; consumes the registered tag-lookup results (addr, hit/lru way, miss, store-buffer hit).
//  On hit: reads the data array and aligns word/byte. On miss: stalls the core, fetches the line from memory, fills the LRU way, replays.

---
 rtl/c_cache_pkg.sv | 56 +++++
 rtl/c_data_array.sv | 39 +++
 rtl/c_cache_stage.sv | 218 +++++++++++++++++++++
 tb/tb_c_cache_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/c_cache_pkg.sv
// -----------------------------------------------------------------------------
// c_cache_pkg
// Shared definitions for the cache (C) stage of the data-memory pipe:
//   - cache geometry (ways, sets, line size) and derived field widths
//   - address field positions (byte, word, offset, index)
//   - FSM state encoding
//   - load alignment helper (word select + optional zero-extended byte)
// No ports (package).
// -----------------------------------------------------------------------------
package c_cache_pkg;

   localparam int WAYS      = 4;
   localparam int SETS      = 4;
   localparam int LINE_BITS = 128;
   localparam int WORD_BITS = 32;

   localparam int ADDR_W    = 20;
   localparam int WAY_W     = 2;
   localparam int INDEX_W   = 2;
   localparam int OFF_W     = 4;   // byte offset within a line
   localparam int WORD_LSB  = 2;   // word select = addr[3:2]
   localparam int BYTE_LSB  = 0;   // byte select = addr[1:0]

   // FSM state encoding
   localparam logic [1:0] ENC_IDLE   = 2'd0;
   localparam logic [1:0] ENC_REQ    = 2'd1;
   localparam logic [1:0] ENC_FILL   = 2'd2;
   localparam logic [1:0] ENC_REPLAY = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = ENC_IDLE,
      ST_REQ    = ENC_REQ,
      ST_FILL   = ENC_FILL,
      ST_REPLAY = ENC_REPLAY
   } c_state_t;

   // Pick one 32-bit word out of a line; for byte accesses return the
   // addressed byte of that word, zero-extended.
   function automatic logic [WORD_BITS-1:0] align_load(
      input logic [LINE_BITS-1:0] line,
      input logic [1:0]           word_sel,
      input logic [1:0]           byte_sel,
      input logic                 is_byte
   );
      logic [WORD_BITS-1:0] word;
      logic [7:0]           byte_val;
      word     = line[{word_sel, 5'b00000} +: WORD_BITS];
      byte_val = word[{byte_sel, 3'b000} +: 8];
      if (is_byte) begin
         align_load = {24'h00_0000, byte_val};
      end else begin
         align_load = word;
      end
   endfunction

endpackage

// File: rtl/c_data_array.sv
// -----------------------------------------------------------------------------
// c_data_array
// Data storage of the cache: WAYS x SETS lines of LINE_BITS each.
// Contents are not reset; line validity is tracked by the tag-lookup stage.
// Ports:
//   clk      in   1          clock
//   wr_en    in   1          write a full line this cycle
//   wr_way   in   WAY_W      way to write
//   wr_index in   INDEX_W    set to write
//   wr_line  in   LINE_BITS  line data to write
//   rd_way   in   WAY_W      way to read (combinational read port)
//   rd_index in   INDEX_W    set to read
//   rd_line  out  LINE_BITS  line read data
// -----------------------------------------------------------------------------
module c_data_array
   import c_cache_pkg::*;
(
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [WAY_W-1:0]     wr_way,
   input  logic [INDEX_W-1:0]   wr_index,
   input  logic [LINE_BITS-1:0] wr_line,
   input  logic [WAY_W-1:0]     rd_way,
   input  logic [INDEX_W-1:0]   rd_index,
   output logic [LINE_BITS-1:0] rd_line
);

   logic [LINE_BITS-1:0] mem_r [0:WAYS-1][0:SETS-1];

   // Full-line write port used by the miss fill.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_way][wr_index] <= wr_line;
      end
   end

   assign rd_line = mem_r[rd_way][rd_index];

endmodule

// File: rtl/c_cache_stage.sv
// -----------------------------------------------------------------------------
// c_cache_stage
// Cache (C) stage of the data-memory pipe. Consumes registered tag-lookup
// results. Hits (and store-buffer forwards) are aligned and registered for
// WB in one cycle. Misses stall the core, fetch the line from memory, fill
// the LRU way, signal the tag stage to install the tag, then replay the load
// from the freshly filled way.
// Ports:
//   clk_i, rsn_i               clock, synchronous active-low reset
//   kill_i                     squash instruction currently in C
//   c_addr_i .. c_pc_i         instruction/lookup fields from the TL/C latch
//   stall_core_o               freeze upstream latches
//   mem_rqst_o, mem_addr_o     line-fetch request and line address
//   mem_ready_i, mem_data_i    returned line (valid while mem_ready_i)
//   fill_valid_o/way_o/addr_o  one-cycle tag-install pulse to the tag stage
//   wb_*_o                     registered load result and int WB control
// -----------------------------------------------------------------------------
module c_cache_stage
   import c_cache_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rsn_i,
   input  logic                 kill_i,
   input  logic [ADDR_W-1:0]    c_addr_i,
   input  logic                 c_rqst_byte_i,
   input  logic [WAY_W-1:0]     c_hit_way_i,
   input  logic [WAY_W-1:0]     c_lru_way_i,
   input  logic                 c_miss_i,
   input  logic                 c_buffer_hit_i,
   input  logic [31:0]          c_buffer_data_i,
   input  logic                 c_int_write_enable_i,
   input  logic [4:0]           c_write_addr_i,
   input  logic                 c_cache_enable_i,
   input  logic [31:0]          c_pc_i,
   output logic                 stall_core_o,
   output logic                 mem_rqst_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   input  logic                 mem_ready_i,
   input  logic [LINE_BITS-1:0] mem_data_i,
   output logic                 fill_valid_o,
   output logic [WAY_W-1:0]     fill_way_o,
   output logic [ADDR_W-1:0]    fill_addr_o,
   output logic                 wb_valid_o,
   output logic [31:0]          wb_data_o,
   output logic                 wb_int_write_enable_o,
   output logic [4:0]           wb_write_addr_o,
   output logic [31:0]          wb_pc_o
);

   c_state_t             state_r;
   logic                 mem_rqst_r;
   logic [ADDR_W-1:0]    mem_addr_r;
   logic [LINE_BITS-1:0] line_r;
   logic                 fill_valid_r;
   logic [WAY_W-1:0]     fill_way_r;
   logic                 kill_r;
   logic                 wb_valid_r;
   logic [31:0]          wb_data_r;
   logic                 wb_we_r;
   logic [4:0]           wb_waddr_r;
   logic [31:0]          wb_pc_r;

   logic                 need_mem_s;
   logic                 squash_s;
   logic [INDEX_W-1:0]   index_s;
   logic [1:0]           word_sel_s;
   logic [1:0]           byte_sel_s;
   logic [ADDR_W-1:0]    line_addr_s;
   logic [WAY_W-1:0]     rd_way_s;
   logic [LINE_BITS-1:0] rd_line_s;
   logic [31:0]          load_data_s;
   logic                 array_we_s;
   logic                 stall_s;

   assign need_mem_s  = c_cache_enable_i & c_miss_i & ~c_buffer_hit_i & ~kill_i;
   assign index_s     = c_addr_i[OFF_W+INDEX_W-1:OFF_W];
   assign word_sel_s  = c_addr_i[WORD_LSB+1:WORD_LSB];
   assign byte_sel_s  = c_addr_i[BYTE_LSB+1:BYTE_LSB];
   assign line_addr_s = {c_addr_i[ADDR_W-1:OFF_W], 4'h0};
   assign array_we_s  = (state_r == ST_FILL);
   // A kill seen at any point of the miss sequence suppresses the replay write.
   assign squash_s    = kill_r | kill_i;

   // Replay must read the way that was just filled, not the stale hit way.
   always_comb begin
      if (state_r == ST_REPLAY) begin
         rd_way_s = c_lru_way_i;
      end else begin
         rd_way_s = c_hit_way_i;
      end
   end

   c_data_array u_data_array (
      .clk      (clk_i),
      .wr_en    (array_we_s),
      .wr_way   (fill_way_r),
      .wr_index (index_s),
      .wr_line  (line_r),
      .rd_way   (rd_way_s),
      .rd_index (index_s),
      .rd_line  (rd_line_s)
   );

   // Load data selection: non-cache ops return 0, a store-buffer forward
   // wins over the array and is taken as already-aligned load data.
   always_comb begin
      if (!c_cache_enable_i) begin
         load_data_s = 32'h0000_0000;
      end else if (c_buffer_hit_i) begin
         load_data_s = c_buffer_data_i;
      end else begin
         load_data_s = align_load(rd_line_s, word_sel_s, byte_sel_s, c_rqst_byte_i);
      end
   end

   // Stall is combinational in IDLE so the core freezes in the miss cycle
   // itself; it drops in REPLAY so the next instruction enters with WB.
   always_comb begin
      case (state_r)
         ST_IDLE:   stall_s = need_mem_s;
         ST_REQ:    stall_s = 1'b1;
         ST_FILL:   stall_s = 1'b1;
         ST_REPLAY: stall_s = 1'b0;
         default:   stall_s = 1'b0;
      endcase
   end

   // Miss FSM with registered memory, fill and write-back outputs.
   always_ff @(posedge clk_i) begin
      if (!rsn_i) begin
         state_r      <= ST_IDLE;
         mem_rqst_r   <= 1'b0;
         mem_addr_r   <= '0;
         line_r       <= '0;
         fill_valid_r <= 1'b0;
         fill_way_r   <= '0;
         kill_r       <= 1'b0;
         wb_valid_r   <= 1'b0;
         wb_data_r    <= 32'h0000_0000;
         wb_we_r      <= 1'b0;
         wb_waddr_r   <= 5'd0;
         wb_pc_r      <= 32'h0000_0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               fill_valid_r <= 1'b0;
               if (need_mem_s) begin
                  state_r    <= ST_REQ;
                  mem_rqst_r <= 1'b1;
                  mem_addr_r <= line_addr_s;
                  kill_r     <= 1'b0;
                  wb_valid_r <= 1'b0;
                  wb_we_r    <= 1'b0;
               end else begin
                  wb_valid_r <= ~kill_i;
                  wb_we_r    <= c_int_write_enable_i & ~kill_i;
                  wb_data_r  <= load_data_s;
                  wb_waddr_r <= c_write_addr_i;
                  wb_pc_r    <= c_pc_i;
               end
            end
            ST_REQ: begin
               wb_valid_r <= 1'b0;
               wb_we_r    <= 1'b0;
               if (kill_i) begin
                  kill_r <= 1'b1;
               end
               if (mem_ready_i) begin
                  state_r      <= ST_FILL;
                  mem_rqst_r   <= 1'b0;
                  line_r       <= mem_data_i;
                  fill_valid_r <= 1'b1;
                  fill_way_r   <= c_lru_way_i;
               end
            end
            ST_FILL: begin
               state_r      <= ST_REPLAY;
               fill_valid_r <= 1'b0;
               wb_valid_r   <= 1'b0;
               wb_we_r      <= 1'b0;
               if (kill_i) begin
                  kill_r <= 1'b1;
               end
            end
            ST_REPLAY: begin
               state_r    <= ST_IDLE;
               kill_r     <= 1'b0;
               wb_valid_r <= ~squash_s;
               wb_we_r    <= c_int_write_enable_i & ~squash_s;
               wb_data_r  <= load_data_s;
               wb_waddr_r <= c_write_addr_i;
               wb_pc_r    <= c_pc_i;
            end
            default: begin
               state_r      <= ST_IDLE;
               mem_rqst_r   <= 1'b0;
               fill_valid_r <= 1'b0;
               kill_r       <= 1'b0;
               wb_valid_r   <= 1'b0;
               wb_we_r      <= 1'b0;
            end
         endcase
      end
   end

   assign stall_core_o          = stall_s;
   assign mem_rqst_o            = mem_rqst_r;
   assign mem_addr_o            = mem_addr_r;
   assign fill_valid_o          = fill_valid_r;
   assign fill_way_o            = fill_way_r;
   assign fill_addr_o           = mem_addr_r;
   assign wb_valid_o            = wb_valid_r;
   assign wb_data_o             = wb_data_r;
   assign wb_int_write_enable_o = wb_we_r;
   assign wb_write_addr_o       = wb_waddr_r;
   assign wb_pc_o               = wb_pc_r;

endmodule

// File: tb/tb_c_cache_stage.sv
// -----------------------------------------------------------------------------
// tb_c_cache_stage
// Directed bench for the cache stage: reset state, word/byte hits, store-
// buffer forward, miss fetch/fill/replay timing, kill handling, reset in REQ.
// -----------------------------------------------------------------------------
module tb_c_cache_stage;

   logic         clk = 1'b0;
   logic         rsn_i;
   logic         kill_i;
   logic [19:0]  c_addr_i;
   logic         c_rqst_byte_i;
   logic [1:0]   c_hit_way_i;
   logic [1:0]   c_lru_way_i;
   logic         c_miss_i;
   logic         c_buffer_hit_i;
   logic [31:0]  c_buffer_data_i;
   logic         c_int_write_enable_i;
   logic [4:0]   c_write_addr_i;
   logic         c_cache_enable_i;
   logic [31:0]  c_pc_i;
   logic         stall_core_o;
   logic         mem_rqst_o;
   logic [19:0]  mem_addr_o;
   logic         mem_ready_i;
   logic [127:0] mem_data_i;
   logic         fill_valid_o;
   logic [1:0]   fill_way_o;
   logic [19:0]  fill_addr_o;
   logic         wb_valid_o;
   logic [31:0]  wb_data_o;
   logic         wb_int_write_enable_o;
   logic [4:0]   wb_write_addr_o;
   logic [31:0]  wb_pc_o;

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] LINE_A = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
   localparam logic [127:0] LINE_B = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'hA1B2_C3D4};
   localparam logic [127:0] LINE_C = {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000};
   localparam logic [127:0] LINE_D = {32'h6666_0003, 32'h6666_0002, 32'h6666_0001, 32'h5A5A_0000};

   always #5 clk = ~clk;

   c_cache_stage dut (
      .clk_i                 (clk),
      .rsn_i                 (rsn_i),
      .kill_i                (kill_i),
      .c_addr_i              (c_addr_i),
      .c_rqst_byte_i         (c_rqst_byte_i),
      .c_hit_way_i           (c_hit_way_i),
      .c_lru_way_i           (c_lru_way_i),
      .c_miss_i              (c_miss_i),
      .c_buffer_hit_i        (c_buffer_hit_i),
      .c_buffer_data_i       (c_buffer_data_i),
      .c_int_write_enable_i  (c_int_write_enable_i),
      .c_write_addr_i        (c_write_addr_i),
      .c_cache_enable_i      (c_cache_enable_i),
      .c_pc_i                (c_pc_i),
      .stall_core_o          (stall_core_o),
      .mem_rqst_o            (mem_rqst_o),
      .mem_addr_o            (mem_addr_o),
      .mem_ready_i           (mem_ready_i),
      .mem_data_i            (mem_data_i),
      .fill_valid_o          (fill_valid_o),
      .fill_way_o            (fill_way_o),
      .fill_addr_o           (fill_addr_o),
      .wb_valid_o            (wb_valid_o),
      .wb_data_o             (wb_data_o),
      .wb_int_write_enable_o (wb_int_write_enable_o),
      .wb_write_addr_o       (wb_write_addr_o),
      .wb_pc_o               (wb_pc_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      kill_i               = 1'b0;
      c_rqst_byte_i        = 1'b0;
      c_miss_i             = 1'b0;
      c_buffer_hit_i       = 1'b0;
      c_buffer_data_i      = 32'h0;
      c_int_write_enable_i = 1'b0;
      c_cache_enable_i     = 1'b0;
      mem_ready_i          = 1'b0;
      mem_data_i           = '0;
   endtask

   // Drive a cache load that hits (or forwards), check no stall, then check WB.
   task automatic hit_load(input string tag, input logic [19:0] addr, input logic is_byte,
                           input logic [1:0] way, input logic [31:0] exp);
      c_addr_i = addr; c_rqst_byte_i = is_byte; c_hit_way_i = way; c_miss_i = 1'b0;
      c_cache_enable_i = 1'b1; c_int_write_enable_i = 1'b1; c_write_addr_i = 5'd3;
      c_pc_i = {12'h100, addr};
      #1 chk({tag, "_stall"}, stall_core_o, 1'b0);
      tick;
      chk({tag, "_valid"}, wb_valid_o, 1'b1);
      chk({tag, "_data"}, wb_data_o, exp);
      chk({tag, "_we"}, wb_int_write_enable_o, 1'b1);
      chk({tag, "_pc"}, wb_pc_o, {12'h100, addr});
      idle_inputs;
   endtask

   // Full miss sequence: enter cycle, `delay` REQ cycles without ready, a
   // ready cycle, FILL, REPLAY. Optional kill in the first REQ cycle.
   task automatic run_miss(input string tag, input logic [19:0] addr, input logic [1:0] lru,
                           input logic [127:0] line, input int delay, input logic is_byte,
                           input logic [31:0] exp, input logic do_kill);
      int stalls;
      logic [19:0] line_addr;
      stalls    = 0;
      line_addr = {addr[19:4], 4'h0};
      c_addr_i = addr; c_rqst_byte_i = is_byte; c_lru_way_i = lru; c_hit_way_i = ~lru;
      c_miss_i = 1'b1; c_buffer_hit_i = 1'b0; c_cache_enable_i = 1'b1;
      c_int_write_enable_i = 1'b1; c_write_addr_i = 5'd17; c_pc_i = {12'h200, addr};
      #1 chk({tag, "_stall_enter"}, stall_core_o, 1'b1);
      if (stall_core_o) stalls++;
      tick;
      for (int i = 0; i < delay; i++) begin
         kill_i = do_kill && (i == 0);
         #1 chk({tag, "_rqst"}, mem_rqst_o, 1'b1);
         chk({tag, "_maddr"}, mem_addr_o, line_addr);
         if (stall_core_o) stalls++;
         tick;
      end
      kill_i = 1'b0; mem_ready_i = 1'b1; mem_data_i = line;
      #1 if (stall_core_o) stalls++;
      tick;
      mem_ready_i = 1'b0; mem_data_i = '0;
      #1 chk({tag, "_fill_valid"}, fill_valid_o, 1'b1);
      chk({tag, "_fill_way"}, fill_way_o, lru);
      chk({tag, "_fill_addr"}, fill_addr_o, line_addr);
      chk({tag, "_rqst_drop"}, mem_rqst_o, 1'b0);
      if (stall_core_o) stalls++;
      tick;
      #1 chk({tag, "_replay_stall"}, stall_core_o, 1'b0);
      chk({tag, "_fill_pulse_end"}, fill_valid_o, 1'b0);
      chk({tag, "_stall_cycles"}, stalls, delay + 3);
      tick;
      chk({tag, "_wb_valid"}, wb_valid_o, !do_kill);
      chk({tag, "_wb_we"}, wb_int_write_enable_o, !do_kill);
      if (!do_kill) begin
         chk({tag, "_wb_data"}, wb_data_o, exp);
         chk({tag, "_wb_waddr"}, wb_write_addr_o, 5'd17);
      end
      idle_inputs;
   endtask

   initial begin
      rsn_i = 1'b0; c_addr_i = 20'h0; c_hit_way_i = 2'd0; c_lru_way_i = 2'd0;
      c_write_addr_i = 5'd0; c_pc_i = 32'h0;
      idle_inputs;
      tick; tick;
      chk("rst_stall", stall_core_o, 1'b0);
      chk("rst_rqst", mem_rqst_o, 1'b0);
      chk("rst_fill", fill_valid_o, 1'b0);
      chk("rst_wb_valid", wb_valid_o, 1'b0);
      chk("rst_wb_data", wb_data_o, 32'h0);
      chk("rst_wb_we", wb_int_write_enable_o, 1'b0);
      rsn_i = 1'b1;
      tick;

      // Preload way1 set2, then word hit on word1.
      run_miss("pre_a", 20'h00024, 2'd1, LINE_A, 1, 1'b0, 32'hD1D1_0001, 1'b0);
      hit_load("hit_word", 20'h00024, 1'b0, 2'd1, 32'hD1D1_0001);

      // Preload way0 set0 with a byte miss, then byte/word hits.
      run_miss("pre_b", 20'h00002, 2'd0, LINE_B, 2, 1'b1, 32'h0000_00B2, 1'b0);
      hit_load("hit_byte2", 20'h00002, 1'b1, 2'd0, 32'h0000_00B2);
      hit_load("hit_byte3", 20'h00003, 1'b1, 2'd0, 32'h0000_00A1);
      hit_load("hit_word0", 20'h00000, 1'b0, 2'd0, 32'hA1B2_C3D4);

      // Store-buffer forward on a tag miss: no memory request.
      c_addr_i = 20'h00F10; c_miss_i = 1'b1; c_buffer_hit_i = 1'b1;
      c_buffer_data_i = 32'h1234_5678; c_cache_enable_i = 1'b1;
      c_int_write_enable_i = 1'b1; c_write_addr_i = 5'd4;
      #1 chk("fwd_stall", stall_core_o, 1'b0);
      tick;
      chk("fwd_rqst", mem_rqst_o, 1'b0);
      chk("fwd_data", wb_data_o, 32'h1234_5678);
      chk("fwd_valid", wb_valid_o, 1'b1);
      idle_inputs;

      // Miss with 5 waiting REQ cycles: 8 stall cycles total.
      run_miss("miss", 20'h0ABC8, 2'd3, LINE_C, 5, 1'b0, 32'h4444_0002, 1'b0);
      hit_load("hit_after_fill", 20'h0ABCC, 1'b0, 2'd3, 32'h4444_0003);

      // Non-cache instruction: data 0, control passed through.
      c_cache_enable_i = 1'b0; c_int_write_enable_i = 1'b1; c_write_addr_i = 5'd9;
      c_pc_i = 32'hCAFE_0010; c_miss_i = 1'b1;
      tick;
      chk("nc_valid", wb_valid_o, 1'b1);
      chk("nc_data", wb_data_o, 32'h0);
      chk("nc_we", wb_int_write_enable_o, 1'b1);
      chk("nc_waddr", wb_write_addr_o, 5'd9);
      chk("nc_pc", wb_pc_o, 32'hCAFE_0010);
      idle_inputs;

      // Kill in IDLE on a hit.
      c_addr_i = 20'h00024; c_hit_way_i = 2'd1; c_cache_enable_i = 1'b1;
      c_int_write_enable_i = 1'b1; kill_i = 1'b1;
      tick;
      chk("kill_idle_valid", wb_valid_o, 1'b0);
      chk("kill_idle_we", wb_int_write_enable_o, 1'b0);
      idle_inputs;

      // Stray mem_ready in IDLE is ignored.
      mem_ready_i = 1'b1; mem_data_i = LINE_D;
      tick;
      chk("stray_ready_rqst", mem_rqst_o, 1'b0);
      chk("stray_ready_fill", fill_valid_o, 1'b0);
      chk("stray_ready_stall", stall_core_o, 1'b0);
      idle_inputs;

      // Kill during REQ: fill still happens, no write-back; line is usable.
      run_miss("kill_req", 20'h00030, 2'd2, LINE_D, 2, 1'b0, 32'h5A5A_0000, 1'b1);
      hit_load("hit_killed_line", 20'h00030, 1'b0, 2'd2, 32'h5A5A_0000);

      // Reset while in REQ, then hit on the case-1 line.
      c_addr_i = 20'h00024; c_lru_way_i = 2'd0; c_miss_i = 1'b1;
      c_cache_enable_i = 1'b1; c_int_write_enable_i = 1'b1;
      tick;
      chk("rreq_rqst_up", mem_rqst_o, 1'b1);
      rsn_i = 1'b0;
      idle_inputs;
      tick;
      chk("rreq_rqst", mem_rqst_o, 1'b0);
      chk("rreq_stall", stall_core_o, 1'b0);
      chk("rreq_fill", fill_valid_o, 1'b0);
      chk("rreq_wb_valid", wb_valid_o, 1'b0);
      chk("rreq_wb_data", wb_data_o, 32'h0);
      chk("rreq_wb_we", wb_int_write_enable_o, 1'b0);
      chk("rreq_wb_waddr", wb_write_addr_o, 5'd0);
      chk("rreq_wb_pc", wb_pc_o, 32'h0);
      rsn_i = 1'b1;
      tick;
      chk("rreq_no_fill_later", fill_valid_o, 1'b0);
      hit_load("hit_after_reset", 20'h00024, 1'b0, 2'd1, 32'hD1D1_0001);

      tick;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
